// File: rtl/iot_arb_pkg.sv
// ---------------------------------------------------------------------------
// iot_arb_pkg
// Shared definitions for the shared-pin arbiter:
//   - arb_state_t : FSM state encoding (IDLE=0, TURN=1, OWN0=2, OWN1=3)
//   - TURN_CNT_W  : width of the turnaround counter (covers TURN_CYCLES 1..255)
//   - HOLD_CNT_W  : width of the owner hold counter (covers MAX_HOLD 2..65535)
// ---------------------------------------------------------------------------
package iot_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN0 = 2'd2,
    OWN1 = 2'd3
  } arb_state_t;

  localparam int TURN_CNT_W = 8;
  localparam int HOLD_CNT_W = 16;

endpackage

// File: rtl/iot_pin_arbiter_if.sv
// ---------------------------------------------------------------------------
// iot_pin_arbiter_if
// Request/grant bundle between two requesters and the shared-pin arbiter.
//   REQ_I_0 / REQ_I_1 : requester wants the pin          (master -> slave)
//   GNT_O_0 / GNT_O_1 : requester owns the pin           (slave -> master)
//   SEL_O             : pin-mux select, 0 = req0, 1 = req1
//   HIZ_O             : force the pin tristate downstream
//   BUSY_O            : arbiter is not idle
//   TOUT_O            : one-cycle hold-timeout preemption pulse
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface iot_pin_arbiter_if;

  logic REQ_I_0;
  logic REQ_I_1;
  logic GNT_O_0;
  logic GNT_O_1;
  logic SEL_O;
  logic HIZ_O;
  logic BUSY_O;
  logic TOUT_O;

  modport master (
    output REQ_I_0, REQ_I_1,
    input  GNT_O_0, GNT_O_1, SEL_O, HIZ_O, BUSY_O, TOUT_O
  );

  modport slave (
    input  REQ_I_0, REQ_I_1,
    output GNT_O_0, GNT_O_1, SEL_O, HIZ_O, BUSY_O, TOUT_O
  );

endinterface

// File: rtl/iot_arb_cnt.sv
// ---------------------------------------------------------------------------
// iot_arb_cnt
// Loadable up-counter that saturates at i_limit and flags o_done while the
// count has reached the limit.
//   clk, rst     : clock, asynchronous active-high reset (count -> 0)
//   i_load       : load i_load_val (has priority over counting)
//   i_load_val   : value to load
//   i_en         : count up by one while below i_limit
//   i_limit      : saturation point
//   o_done       : count == i_limit (or above, after a high load)
// ---------------------------------------------------------------------------
module iot_arb_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  // Count register: load, saturating increment, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt < i_limit)) begin
      r_cnt <= r_cnt + ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt >= i_limit);

endmodule

// File: rtl/iot_pin_arbiter.sv
// ---------------------------------------------------------------------------
// iot_pin_arbiter
// Two-requester arbiter for a shared bidirectional pin. Every owner change
// passes through a TURN phase of TURN_CYCLES cycles with the pin tristated
// and no grant, so two drivers never fight. Ties in IDLE go round-robin
// against the last owner (requester 0 wins the first tie after reset).
//
// Parameters:
//   TURN_CYCLES : hi-Z cycles before any owner change (1..255)
//   MAX_HOLD    : owner hold limit in cycles, timeout build only (2..65535)
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : iot_pin_arbiter_if.slave (requests in, grant/select/status out)
// Build option:
//   IOT_ARB_TIMEOUT_EN : when defined, an owner that has held the pin for
//   MAX_HOLD cycles is preempted if the other requester is waiting
//   (TOUT_O pulses). When undefined, no hold counter exists, TOUT_O is 0
//   and the owner keeps the pin until it releases.
// ---------------------------------------------------------------------------
module iot_pin_arbiter
  import iot_arb_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_HOLD    = 256
) (
  input  logic               clk,
  input  logic               rst,
  iot_pin_arbiter_if.slave   bus
);

  // TURN is exited on the edge where the counter (zeroed on entry) has
  // reached TURN_CYCLES-1, giving exactly TURN_CYCLES cycles in TURN.
  localparam logic [TURN_CNT_W-1:0] TURN_LIMIT = TURN_CNT_W'(TURN_CYCLES - 1);

  arb_state_t r_state;
  logic       r_target;
  logic       r_last_owner;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_sel;
  logic       r_hiz;
  logic       r_busy;

  logic       w_req0;
  logic       w_req1;
  logic       w_target_req;
  logic       w_turn_done;
  logic       w_hold_expire0;
  logic       w_hold_expire1;

  assign w_req0       = bus.REQ_I_0;
  assign w_req1       = bus.REQ_I_1;
  assign w_target_req = r_target ? w_req1 : w_req0;

  // The counter is held at zero outside TURN, so it starts from zero on
  // every TURN entry without needing a separate load strobe.
  iot_arb_cnt #(
    .WIDTH (TURN_CNT_W)
  ) u_turn_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state != TURN),
    .i_load_val ({TURN_CNT_W{1'b0}}),
    .i_en       (r_state == TURN),
    .i_limit    (TURN_LIMIT),
    .o_done     (w_turn_done)
  );

`ifdef IOT_ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD - 1);

  logic w_owning;
  logic w_hold_done;
  logic r_tout;

  assign w_owning = (r_state == OWN0) || (r_state == OWN1);

  // Zeroed on every OWN entry; saturates so a late request from the other
  // side still preempts immediately once the limit has passed.
  iot_arb_cnt #(
    .WIDTH (HOLD_CNT_W)
  ) u_hold_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (!w_owning),
    .i_load_val ({HOLD_CNT_W{1'b0}}),
    .i_en       (w_owning),
    .i_limit    (HOLD_LIMIT),
    .o_done     (w_hold_done)
  );

  assign w_hold_expire0 = w_hold_done && w_req1;
  assign w_hold_expire1 = w_hold_done && w_req0;
  assign bus.TOUT_O     = r_tout;
`else
  assign w_hold_expire0 = 1'b0;
  assign w_hold_expire1 = 1'b0;
  assign bus.TOUT_O     = 1'b0;
`endif

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_target     <= 1'b0;
      r_last_owner <= 1'b1;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_sel        <= 1'b0;
      r_hiz        <= 1'b1;
      r_busy       <= 1'b0;
`ifdef IOT_ARB_TIMEOUT_EN
      r_tout       <= 1'b0;
`endif
    end else begin
`ifdef IOT_ARB_TIMEOUT_EN
      r_tout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_req0 || w_req1) begin
            // Single request picks itself; a tie goes to the non-last owner.
            r_state  <= TURN;
            r_target <= (w_req0 && w_req1) ? ~r_last_owner : w_req1;
            r_sel    <= (w_req0 && w_req1) ? ~r_last_owner : w_req1;
            r_busy   <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end

        TURN: begin
          if (!w_turn_done) begin
            r_state <= TURN;
          end else if (w_target_req) begin
            r_state      <= r_target ? OWN1 : OWN0;
            r_gnt0       <= ~r_target;
            r_gnt1       <= r_target;
            r_hiz        <= 1'b0;
            r_last_owner <= r_target;
          end else begin
            // Target gave up during turnaround: no grant.
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        OWN0: begin
          if (!w_req0 || w_hold_expire0) begin
            r_gnt0 <= 1'b0;
            r_hiz  <= 1'b1;
            if (w_req1) begin
              r_state  <= TURN;
              r_target <= 1'b1;
              r_sel    <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
`ifdef IOT_ARB_TIMEOUT_EN
            // Voluntary release takes precedence over timeout reporting.
            r_tout <= w_req0 && w_hold_expire0;
`endif
          end else begin
            r_state <= OWN0;
          end
        end

        OWN1: begin
          if (!w_req1 || w_hold_expire1) begin
            r_gnt1 <= 1'b0;
            r_hiz  <= 1'b1;
            if (w_req0) begin
              r_state  <= TURN;
              r_target <= 1'b0;
              r_sel    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
`ifdef IOT_ARB_TIMEOUT_EN
            r_tout <= w_req1 && w_hold_expire1;
`endif
          end else begin
            r_state <= OWN1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_hiz   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.GNT_O_0 = r_gnt0;
  assign bus.GNT_O_1 = r_gnt1;
  assign bus.SEL_O   = r_sel;
  assign bus.HIZ_O   = r_hiz;
  assign bus.BUSY_O  = r_busy;

endmodule

// File: tb/tb_iot_pin_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iot_pin_arbiter
// Directed bench for iot_pin_arbiter (TURN_CYCLES=2, MAX_HOLD=8). Expected
// output vectors {GNT0,GNT1,SEL,HIZ,BUSY,TOUT} are queued when a step is
// driven and compared when the DUT has produced the result (#1 after the
// edge). Honours IOT_ARB_TIMEOUT_EN for the hold-limit scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iot_pin_arbiter;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   chk_cnt;
  exp_t sb[$];

  iot_pin_arbiter_if bus_if ();

  iot_pin_arbiter #(
    .TURN_CYCLES (2),
    .MAX_HOLD    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] observed();
    return {bus_if.GNT_O_0, bus_if.GNT_O_1, bus_if.SEL_O,
            bus_if.HIZ_O, bus_if.BUSY_O, bus_if.TOUT_O};
  endfunction

  task automatic push(input string tag, input logic [5:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t       e;
    logic [5:0] obs;
    e   = sb.pop_front();
    obs = observed();
    chk_cnt++;
    assert (obs === e.v) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b (g0 g1 sel hiz busy tout)",
                e.tag, obs, e.v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock step: queue the expectation, advance, compare.
  task automatic step(input string tag, input logic [5:0] v);
    push(tag, v);
    tick();
    check_pop();
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    rst = 1'b1;
    bus_if.REQ_I_0 = 1'b0;
    bus_if.REQ_I_1 = 1'b0;
    repeat (2) tick();
    push("reset_state", 6'b000100);
    check_pop();
    rst = 1'b0;
    step("idle_no_req", 6'b000100);

    // Single request from requester 0: grant two cycles after TURN entry.
    bus_if.REQ_I_0 = 1'b1;
    step("r0_turn_entry", 6'b000110);
    step("r0_turn_2", 6'b000110);
    step("r0_grant", 6'b100010);
    step("r0_hold", 6'b100010);
    bus_if.REQ_I_0 = 1'b0;
    step("r0_release_idle", 6'b000100);

    // Tie right after reset: requester 0 first, then 1 after release.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus_if.REQ_I_0 = 1'b1;
    bus_if.REQ_I_1 = 1'b1;
    step("tie_turn0", 6'b000110);
    step("tie_turn0_2", 6'b000110);
    step("tie_grant0", 6'b100010);
    step("tie_hold0", 6'b100010);
    bus_if.REQ_I_0 = 1'b0;
    step("handover_turn1", 6'b001110);
    step("handover_turn1_2", 6'b001110);
    step("handover_grant1", 6'b011010);
    // Requester 0 rising while 1 owns must not disturb the grant.
    bus_if.REQ_I_0 = 1'b1;
    step("wait_no_effect", 6'b011010);
    bus_if.REQ_I_1 = 1'b0;
    step("back_turn0", 6'b000110);
    step("back_turn0_2", 6'b000110);
    step("back_grant0", 6'b100010);
    bus_if.REQ_I_0 = 1'b0;
    step("back_idle_sel0", 6'b000100);
    // Round-robin: last owner 0, so a tie now goes to requester 1.
    bus_if.REQ_I_0 = 1'b1;
    bus_if.REQ_I_1 = 1'b1;
    step("rr_turn1", 6'b001110);
    step("rr_turn1_2", 6'b001110);
    step("rr_grant1", 6'b011010);

    // Asynchronous reset while requester 1 owns: outputs clear without an edge.
    rst = 1'b1;
    push("async_rst_own1", 6'b000100);
    #1;
    check_pop();
    bus_if.REQ_I_0 = 1'b0;
    bus_if.REQ_I_1 = 1'b0;
    rst = 1'b0;
    step("post_rst_idle", 6'b000100);

    // One-cycle pulse from requester 1: TURN then IDLE, no grant, SEL stays 1.
    bus_if.REQ_I_1 = 1'b1;
    step("pulse_turn1", 6'b001110);
    bus_if.REQ_I_1 = 1'b0;
    step("pulse_turn1_2", 6'b001110);
    step("pulse_abort_idle", 6'b001100);
    step("pulse_idle_hold_sel", 6'b001100);

    // Requester 0 holds while requester 1 waits.
    bus_if.REQ_I_0 = 1'b1;
    step("hold_turn0", 6'b000110);
    step("hold_turn0_2", 6'b000110);
    step("hold_grant0", 6'b100010);
    bus_if.REQ_I_1 = 1'b1;
`ifdef IOT_ARB_TIMEOUT_EN
    // Granted at the edge above; owner cycles 2..8 follow, preempt on the next.
    for (int i = 0; i < 7; i++) step("hold_before_limit", 6'b100010);
    step("tout_preempt", 6'b001111);
    step("tout_turn1_2", 6'b001110);
    step("tout_grant1", 6'b011010);
`else
    for (int i = 0; i < 1000; i++) step("hold_no_timeout", 6'b100010);
`endif
    bus_if.REQ_I_0 = 1'b0;
    bus_if.REQ_I_1 = 1'b0;
    tick();
    step("final_idle", 6'b000100);

    if (sb.size() != 0) begin
      chk_cnt++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
